register_scoreboard: RTL and testbench

Tracks outstanding register writes between the decode stage and writeback, and drives the decode stage's `register_read_1_contended` / `register_read_2_contended` inputs.
- Decode reserves a destination register when it hands an instruction to the next stage.
- Writeback releases the register when the result is committed.
- A read of any register with writes still in flight is flagged as contended, so decode stalls.
- Sits beside the register file; it is the single arbiter of read-after-write hazards for the pipeline.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/pending_counter.sv | 35 +++
 rtl/register_scoreboard.sv | 77 +++++++
 tb/tb_register_scoreboard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural register count and register index type,
// common to decode, register file and scoreboard.
package cpu_pkg;

  localparam int unsigned NUM_REGISTERS           = 32;
  localparam int unsigned REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

  typedef logic [REGISTER_INDEXING_WIDTH-1:0] register_index_t;

endpackage

// File: rtl/pending_counter.sv
// Per-register count of in-flight writes; simultaneous inc and dec cancel out.
module pending_counter #(
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic at_max,
  output logic nonzero,
  output logic underflow
);

  localparam int unsigned COUNT_WIDTH = $clog2(MAX_PENDING + 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_PENDING);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + COUNT_WIDTH'(1);
    end else if (dec && !inc && nonzero) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    at_max    = (count == MAX_COUNT);
    nonzero   = (count != '0);
    underflow = dec && !inc && !nonzero;
  end

endmodule

// File: rtl/register_scoreboard.sv
// Read-after-write hazard tracker: counts in-flight writes per register and
// flags decode source reads of registers that still have writes pending.
module register_scoreboard #(
  parameter int unsigned NUM_REGISTERS = cpu_pkg::NUM_REGISTERS,
  parameter int unsigned MAX_PENDING   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(NUM_REGISTERS)-1:0] read_1_register,
  output logic                             read_1_contended,
  input  logic [$clog2(NUM_REGISTERS)-1:0] read_2_register,
  output logic                             read_2_contended,
  input  logic                             reserve_valid,
  input  logic [$clog2(NUM_REGISTERS)-1:0] reserve_register,
  output logic                             reserve_ready,
  input  logic                             release_valid,
  input  logic [$clog2(NUM_REGISTERS)-1:0] release_register,
  output logic                             pending_any,
  output logic                             underflow_error
);

  localparam int unsigned IW = $clog2(NUM_REGISTERS);

  logic [NUM_REGISTERS-1:0] inc;
  logic [NUM_REGISTERS-1:0] dec;
  logic [NUM_REGISTERS-1:0] at_max;
  logic [NUM_REGISTERS-1:0] nonzero;
  logic [NUM_REGISTERS-1:0] underflow;
  logic                     reserve_accepted;

  // Register 0 is hardwired zero: no counter, never busy, never errors.
  assign at_max[0]    = 1'b0;
  assign nonzero[0]   = 1'b0;
  assign underflow[0] = 1'b0;

  always_comb begin
    reserve_ready = (reserve_register == '0) || !at_max[reserve_register] ||
                    (release_valid && (release_register == reserve_register));
    reserve_accepted = reserve_valid && reserve_ready;
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < NUM_REGISTERS; r++) begin
      inc[r] = reserve_accepted && (reserve_register == IW'(r));
      dec[r] = release_valid && (release_register == IW'(r));
    end
  end

  for (genvar r = 1; r < NUM_REGISTERS; r++) begin : g_counter
    pending_counter #(
      .MAX_PENDING(MAX_PENDING)
    ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[r]),
      .dec      (dec[r]),
      .at_max   (at_max[r]),
      .nonzero  (nonzero[r]),
      .underflow(underflow[r])
    );
  end

  // Reads see registered counts only, so a same-cycle reserve never self-stalls.
  always_comb begin
    read_1_contended = nonzero[read_1_register];
    read_2_contended = nonzero[read_2_register];
    pending_any      = |nonzero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_error <= 1'b0;
    end else if (|underflow) begin
      underflow_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed-vector bench for register_scoreboard with hand-computed expectations.
module tb_register_scoreboard;

  logic                     clk;
  logic                     rst;
  cpu_pkg::register_index_t read_1_register;
  logic                     read_1_contended;
  cpu_pkg::register_index_t read_2_register;
  logic                     read_2_contended;
  logic                     reserve_valid;
  cpu_pkg::register_index_t reserve_register;
  logic                     reserve_ready;
  logic                     release_valid;
  cpu_pkg::register_index_t release_register;
  logic                     pending_any;
  logic                     underflow_error;

  int checks   = 0;
  int failures = 0;

  register_scoreboard #(
    .NUM_REGISTERS(32),
    .MAX_PENDING  (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_1_register (read_1_register),
    .read_1_contended(read_1_contended),
    .read_2_register (read_2_register),
    .read_2_contended(read_2_contended),
    .reserve_valid   (reserve_valid),
    .reserve_register(reserve_register),
    .reserve_ready   (reserve_ready),
    .release_valid   (release_valid),
    .release_register(release_register),
    .pending_any     (pending_any),
    .underflow_error (underflow_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle mid-cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reserve_valid = 1'b0;
    release_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    read_1_register = 5'd0;
    read_2_register = 5'd0;
    reserve_valid = 1'b0;
    reserve_register = 5'd0;
    release_valid = 1'b0;
    release_register = 5'd0;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    read_1_register = 5'd0; read_2_register = 5'd5; reserve_register = 5'd31;
    #1;
    check("rst_c1_r0", read_1_contended, 0);
    check("rst_c2_r5", read_2_contended, 0);
    check("rst_ready", reserve_ready, 1);
    check("rst_pending", pending_any, 0);
    check("rst_err", underflow_error, 0);
    read_1_register = 5'd31;
    #1;
    check("rst_c1_r31", read_1_contended, 0);

    // Reserve x5 with same-cycle read of x5: no self-stall, contended next cycle
    reserve_valid = 1'b1; reserve_register = 5'd5; read_1_register = 5'd5;
    #1;
    check("x5_same_cycle", read_1_contended, 0);
    cycle();
    idle();
    #1;
    check("x5_next_cycle", read_1_contended, 1);
    check("x5_pending", pending_any, 1);
    cycle();
    release_valid = 1'b1; release_register = 5'd5;
    #1;
    check("x5_release_nobypass", read_1_contended, 1);
    cycle();
    idle();
    #1;
    check("x5_released", read_1_contended, 0);
    check("x5_pending_clear", pending_any, 0);

    // Saturate x7 at three reservations
    read_1_register = 5'd7;
    for (int i = 0; i < 3; i++) begin
      reserve_valid = 1'b1; reserve_register = 5'd7;
      #1;
      check("x7_fill_ready", reserve_ready, 1);
      cycle();
    end
    idle();
    reserve_register = 5'd7;
    #1;
    check("x7_full_ready", reserve_ready, 0);
    reserve_register = 5'd8;
    #1;
    check("x8_ready", reserve_ready, 1);
    // Full and blocked reserve is ignored
    reserve_valid = 1'b1; reserve_register = 5'd7;
    cycle();
    // Reserve with same-register release at full count
    release_valid = 1'b1; release_register = 5'd7;
    #1;
    check("x7_full_with_release_ready", reserve_ready, 1);
    cycle();
    idle();
    reserve_register = 5'd7;
    #1;
    check("x7_still_full", reserve_ready, 0);
    for (int i = 0; i < 3; i++) begin
      release_valid = 1'b1; release_register = 5'd7;
      cycle();
      idle();
      #1;
      check("x7_drain_ready", reserve_ready, 1);
      check("x7_drain_contended", read_1_contended, (i < 2) ? 1 : 0);
    end
    check("x7_no_err", underflow_error, 0);

    // Reserve+release x3 at count 1 keeps count at 1
    read_2_register = 5'd3;
    reserve_valid = 1'b1; reserve_register = 5'd3;
    cycle();
    release_valid = 1'b1; release_register = 5'd3;
    cycle();
    idle();
    #1;
    check("x3_both_contended", read_2_contended, 1);
    release_valid = 1'b1; release_register = 5'd3;
    cycle();
    idle();
    #1;
    check("x3_single_release", read_2_contended, 0);
    check("x3_no_err", underflow_error, 0);

    // Underflow on x9 is sticky until reset
    release_valid = 1'b1; release_register = 5'd9;
    #1;
    check("x9_err_not_yet", underflow_error, 0);
    cycle();
    idle();
    #1;
    check("x9_err_set", underflow_error, 1);
    cycle();
    cycle();
    check("x9_err_sticky", underflow_error, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("x9_err_cleared", underflow_error, 0);

    // Register 0 never tracked
    read_1_register = 5'd0;
    for (int i = 0; i < 4; i++) begin
      reserve_valid = 1'b1; reserve_register = 5'd0;
      release_valid = (i != 1); release_register = 5'd0;
      if (i == 2) reserve_valid = 1'b0;
      cycle();
      idle();
      #1;
      check("x0_contended", read_1_contended, 0);
      check("x0_pending", pending_any, 0);
      check("x0_err", underflow_error, 0);
    end
    reserve_register = 5'd0;
    #1;
    check("x0_ready", reserve_ready, 1);

    // Reset discards in-flight reservations
    read_2_register = 5'd12;
    reserve_valid = 1'b1; reserve_register = 5'd12;
    cycle();
    idle();
    #1;
    check("x12_reserved", read_2_contended, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("x12_after_rst", read_2_contended, 0);
    check("x12_pending_after_rst", pending_any, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
